round_key_sched: RTL and testbench

Sequencer between the AES cipher datapath and the key expansion block (key_exp_top). It accepts a 128-bit cipher key with a valid/ready handshake, then steps the expansion round index from 0 to NR. For each round it waits the expansion latency, registers the round key, and offers it downstream on a valid/ready interface. This keeps the datapath free of any knowledge of key-expansion timing.

---
 rtl/aes_pkg.sv | 14 +
 rtl/round_key_sched.sv | 113 +++++++++++
 tb/tb_round_key_sched.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES widths, round counts and the round-key sequencer state encoding.
package aes_pkg;

  localparam int AES_BLK_W = 128;
  localparam int ROUND_W   = 5;
  localparam int NR_AES128 = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2
  } rks_state_t;

endpackage

// File: rtl/round_key_sched.sv
// Steps key expansion through rounds 0..NR, registering each round key KEXP_LAT cycles after
// the round index moves; a presented key holds until rk_ready, so backpressure just stalls the schedule.
module round_key_sched
  import aes_pkg::*;
#(
  parameter int NR       = NR_AES128,
  parameter int KEXP_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [AES_BLK_W-1:0] key_in,
  input  logic                 flush,
  output logic [ROUND_W-1:0]   kexp_round,
  output logic [AES_BLK_W-1:0] kexp_key,
  input  logic [AES_BLK_W-1:0] kexp_key_out,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [AES_BLK_W-1:0] rk_data,
  output logic [ROUND_W-1:0]   rk_round,
  output logic                 rk_last,
  output logic                 busy
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NR);
  localparam logic [2:0]         CNT_LAST   = 3'(KEXP_LAT - 1);

  rks_state_t state, state_nxt;
  logic [2:0] lat_cnt;
  logic       accept;
  logic       capture;
  logic       advance;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (start_valid) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == CNT_LAST) begin
          capture   = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (rk_ready) begin
          if (rk_round == LAST_ROUND) begin
            state_nxt = IDLE;
          end else begin
            advance   = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort overrides everything, including a key offered in the same cycle.
    if (flush) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      capture   = 1'b0;
      advance   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cnt    <= '0;
      kexp_round <= '0;
      kexp_key   <= '0;
      rk_data    <= '0;
      rk_round   <= '0;
    end else begin
      if (accept) begin
        kexp_key   <= key_in;
        kexp_round <= '0;
        lat_cnt    <= '0;
      end else if (advance) begin
        kexp_round <= kexp_round + 5'd1;
        lat_cnt    <= '0;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt + 3'd1;
      end
      if (capture) begin
        rk_data  <= kexp_key_out;
        rk_round <= kexp_round;
      end
    end
  end

  // Held low through reset so nothing handshakes against a block still being cleared.
  assign start_ready = (state == IDLE) && !reset;
  assign rk_valid    = (state == PRESENT);
  assign busy        = (state != IDLE);
  assign rk_last     = (rk_round == LAST_ROUND);

endmodule

// File: tb/tb_round_key_sched.sv
// Directed bench: two schedulers (KEXP_LAT 1 and 3) fed by an AES-128 key expansion model.
module tb_round_key_sched;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam logic [127:0] K0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         rk_ready = 1'b1;
  logic [127:0] key_in = '0;

  logic         start_valid_a = 1'b0, start_ready_a, rk_valid_a, rk_last_a, busy_a;
  logic [4:0]   kexp_round_a, rk_round_a;
  logic [127:0] kexp_key_a, kexp_key_out_a, rk_data_a;
  logic         start_valid_b = 1'b0, start_ready_b, rk_valid_b, rk_last_b, busy_b;
  logic [4:0]   kexp_round_b, rk_round_b;
  logic [127:0] kexp_key_b, kexp_key_out_b, rk_data_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  round_key_sched #(.NR(10), .KEXP_LAT(LAT_A)) dut_a (
    .clk(clk), .reset(reset), .start_valid(start_valid_a), .start_ready(start_ready_a),
    .key_in(key_in), .flush(flush), .kexp_round(kexp_round_a), .kexp_key(kexp_key_a),
    .kexp_key_out(kexp_key_out_a), .rk_valid(rk_valid_a), .rk_ready(rk_ready),
    .rk_data(rk_data_a), .rk_round(rk_round_a), .rk_last(rk_last_a), .busy(busy_a));

  round_key_sched #(.NR(10), .KEXP_LAT(LAT_B)) dut_b (
    .clk(clk), .reset(reset), .start_valid(start_valid_b), .start_ready(start_ready_b),
    .key_in(key_in), .flush(flush), .kexp_round(kexp_round_b), .kexp_key(kexp_key_b),
    .kexp_key_out(kexp_key_out_b), .rk_valid(rk_valid_b), .rk_ready(rk_ready),
    .rk_data(rk_data_b), .rk_round(rk_round_b), .rk_last(rk_last_b), .busy(busy_b));

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] key, input int round);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rcon;
    {w0, w1, w2, w3} = key;
    rcon = 8'h01;
    for (int r = 0; r < round; r++) begin
      t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      rcon = rcon[7] ? ({rcon[6:0], 1'b0} ^ 8'h1b) : {rcon[6:0], 1'b0};
    end
    return {w0, w1, w2, w3};
  endfunction

  // Published vectors where known, expansion model elsewhere.
  function automatic logic [127:0] exp_rk(input logic [127:0] key, input int r);
    if (key == K0 && r == 1) return RK1;
    if (key == K0 && r == 10) return RK10;
    if (r == 0) return key;
    return expand(key, r);
  endfunction

  // Key expansion models: output is corrupted until the inputs have been stable long enough.
  logic [4:0]   last_round_a = '0, last_round_b = '0;
  logic [127:0] last_key_a = '0, last_key_b = '0;
  int age_a = 0, age_b = 0, n_a, n_b;

  always_comb begin
    n_a = ((kexp_round_a !== last_round_a) || (kexp_key_a !== last_key_a)) ? 0 :
          ((age_a < 15) ? age_a + 1 : 15);
    n_b = ((kexp_round_b !== last_round_b) || (kexp_key_b !== last_key_b)) ? 0 :
          ((age_b < 15) ? age_b + 1 : 15);
  end

  always_comb begin
    kexp_key_out_a = expand(kexp_key_a, int'(kexp_round_a));
    if (n_a < LAT_A - 1) kexp_key_out_a = ~kexp_key_out_a;
    kexp_key_out_b = expand(kexp_key_b, int'(kexp_round_b));
    if (n_b < LAT_B - 1) kexp_key_out_b = ~kexp_key_out_b;
  end

  always @(posedge clk) begin
    last_round_a <= kexp_round_a;
    last_key_a   <= kexp_key_a;
    age_a        <= n_a;
    last_round_b <= kexp_round_b;
    last_key_b   <= kexp_key_b;
    age_b        <= n_b;
  end

  task automatic start_a(input logic [127:0] key);
    @(negedge clk);
    start_valid_a = 1'b1;
    key_in = key;
    @(negedge clk);
    start_valid_a = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rk_ready = 1'b1;
    while ((busy_a || busy_b) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy_a || busy_b) begin
      errors++;
      $display("FAIL drain: busy_a=%b busy_b=%b after %0d cycles, want idle", busy_a, busy_b, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (start_ready_a !== 1'b0) begin errors++; $display("FAIL reset_start_ready: got %b want 0", start_ready_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    checks++; if (rk_valid_a !== 1'b0) begin errors++; $display("FAIL reset_rk_valid: got %b want 0", rk_valid_a); end
    checks++; if (kexp_round_a !== 5'd0) begin errors++; $display("FAIL reset_kexp_round: got %0d want 0", kexp_round_a); end
    checks++; if (kexp_key_a !== 128'h0) begin errors++; $display("FAIL reset_kexp_key: got %h want 0", kexp_key_a); end
    checks++; if (rk_data_a !== 128'h0) begin errors++; $display("FAIL reset_rk_data: got %h want 0", rk_data_a); end
    checks++; if (rk_round_a !== 5'd0) begin errors++; $display("FAIL reset_rk_round: got %0d want 0", rk_round_a); end
    checks++; if (rk_last_a !== 1'b0) begin errors++; $display("FAIL reset_rk_last: got %b want 0", rk_last_a); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (start_ready_a !== 1'b1) begin errors++; $display("FAIL release_start_ready_a: got %b want 1", start_ready_a); end
    checks++; if (start_ready_b !== 1'b1) begin errors++; $display("FAIL release_start_ready_b: got %b want 1", start_ready_b); end
  endtask

  task automatic test_basic();
    logic exp_v;
    int   r;
    rk_ready = 1'b1;
    @(negedge clk);
    start_valid_a = 1'b1;
    key_in = K0;
    checks++; if (start_ready_a !== 1'b1) begin errors++; $display("FAIL basic_start_ready: got %b want 1", start_ready_a); end
    @(negedge clk);
    start_valid_a = 1'b0;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL basic_busy_t0: got %b want 1", busy_a); end
    checks++; if (kexp_round_a !== 5'd0) begin errors++; $display("FAIL basic_kexp_round_t0: got %0d want 0", kexp_round_a); end
    checks++; if (kexp_key_a !== K0) begin errors++; $display("FAIL basic_kexp_key: got %h want %h", kexp_key_a, K0); end
    checks++; if (rk_valid_a !== 1'b0) begin errors++; $display("FAIL basic_valid_t0: got %b want 0", rk_valid_a); end
    for (int t = 1; t <= 22; t++) begin
      @(negedge clk);
      exp_v = (t < 22) && (t % 2 == 1);
      checks++; if (rk_valid_a !== exp_v) begin errors++; $display("FAIL basic_valid t=%0d: got %b want %b", t, rk_valid_a, exp_v); end
      checks++; if (busy_a !== 1'(t < 22)) begin errors++; $display("FAIL basic_busy t=%0d: got %b want %b", t, busy_a, t < 22); end
      if (exp_v) begin
        r = (t - 1) / 2;
        checks++; if (rk_round_a !== 5'(r)) begin errors++; $display("FAIL basic_round t=%0d: got %0d want %0d", t, rk_round_a, r); end
        checks++; if (rk_data_a !== exp_rk(K0, r)) begin errors++; $display("FAIL basic_data r=%0d: got %h want %h", r, rk_data_a, exp_rk(K0, r)); end
        checks++; if (rk_last_a !== 1'(r == 10)) begin errors++; $display("FAIL basic_last r=%0d: got %b want %b", r, rk_last_a, r == 10); end
      end
    end
    checks++; if (start_ready_a !== 1'b1) begin errors++; $display("FAIL basic_start_ready_end: got %b want 1", start_ready_a); end
  endtask

  task automatic test_backpressure();
    start_a(K0);
    for (int t = 1; t <= 26; t++) begin
      @(negedge clk);
      if (t >= 7 && t <= 11) begin
        checks++; if (rk_valid_a !== 1'b1) begin errors++; $display("FAIL bp_valid t=%0d: got %b want 1", t, rk_valid_a); end
        checks++; if (rk_round_a !== 5'd3) begin errors++; $display("FAIL bp_round t=%0d: got %0d want 3", t, rk_round_a); end
        checks++; if (kexp_round_a !== 5'd3) begin errors++; $display("FAIL bp_kexp_round t=%0d: got %0d want 3", t, kexp_round_a); end
        checks++; if (rk_data_a !== exp_rk(K0, 3)) begin errors++; $display("FAIL bp_data t=%0d: got %h want %h", t, rk_data_a, exp_rk(K0, 3)); end
      end
      if (t == 12) begin
        checks++; if (rk_valid_a !== 1'b0) begin errors++; $display("FAIL bp_valid_after: got %b want 0", rk_valid_a); end
        checks++; if (kexp_round_a !== 5'd4) begin errors++; $display("FAIL bp_kexp_round_after: got %0d want 4", kexp_round_a); end
      end
      if (t == 13) begin
        checks++; if (rk_valid_a !== 1'b1 || rk_round_a !== 5'd4) begin errors++; $display("FAIL bp_round4: got valid=%b round=%0d want 1/4", rk_valid_a, rk_round_a); end
        checks++; if (rk_data_a !== exp_rk(K0, 4)) begin errors++; $display("FAIL bp_data4: got %h want %h", rk_data_a, exp_rk(K0, 4)); end
      end
      if (t == 25) begin
        checks++; if (busy_a !== 1'b1 || rk_round_a !== 5'd10) begin errors++; $display("FAIL bp_last: got busy=%b round=%0d want 1/10", busy_a, rk_round_a); end
      end
      if (t == 26) begin
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL bp_done: got busy=%b want 0", busy_a); end
      end
      if (t == 6) rk_ready = 1'b0;
      if (t == 11) rk_ready = 1'b1;
    end
  endtask

  task automatic test_latency();
    logic exp_v;
    int   r;
    @(negedge clk);
    start_valid_b = 1'b1;
    key_in = K0;
    @(negedge clk);
    start_valid_b = 1'b0;
    checks++; if (busy_b !== 1'b1 || rk_valid_b !== 1'b0) begin errors++; $display("FAIL lat_t0: got busy=%b valid=%b want 1/0", busy_b, rk_valid_b); end
    for (int t = 1; t <= 44; t++) begin
      @(negedge clk);
      exp_v = (t < 44) && (t % 4 == 3);
      checks++; if (rk_valid_b !== exp_v) begin errors++; $display("FAIL lat_valid t=%0d: got %b want %b", t, rk_valid_b, exp_v); end
      if (exp_v) begin
        r = (t - 3) / 4;
        checks++; if (rk_round_b !== 5'(r)) begin errors++; $display("FAIL lat_round t=%0d: got %0d want %0d", t, rk_round_b, r); end
        checks++; if (rk_data_b !== exp_rk(K0, r)) begin errors++; $display("FAIL lat_data r=%0d: got %h want %h", r, rk_data_b, exp_rk(K0, r)); end
        checks++; if (rk_last_b !== 1'(r == 10)) begin errors++; $display("FAIL lat_last r=%0d: got %b want %b", r, rk_last_b, r == 10); end
      end
    end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL lat_done: got busy=%b want 0", busy_b); end
  endtask

  task automatic test_flush();
    start_a(K0);
    repeat (11) @(negedge clk);
    checks++; if (rk_valid_a !== 1'b1 || rk_round_a !== 5'd5) begin errors++; $display("FAIL flush_pre: got valid=%b round=%0d want 1/5", rk_valid_a, rk_round_a); end
    flush = 1'b1;
    rk_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (rk_valid_a !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", rk_valid_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy_a); end
    checks++; if (start_ready_a !== 1'b1) begin errors++; $display("FAIL flush_start_ready: got %b want 1", start_ready_a); end
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      checks++; if (rk_valid_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL flush_no_round6 t=%0d: got valid=%b busy=%b want 0/0", t, rk_valid_a, busy_a); end
    end
    flush = 1'b1;
    start_valid_a = 1'b1;
    key_in = K1;
    @(negedge clk);
    flush = 1'b0;
    start_valid_a = 1'b0;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL flush_vs_start: got busy=%b want 0", busy_a); end
    checks++; if (kexp_key_a !== K0) begin errors++; $display("FAIL flush_vs_start_key: got %h want %h", kexp_key_a, K0); end
  endtask

  task automatic test_async_reset();
    start_a(K0);
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy_a !== 1'b1 || rk_valid_a !== 1'b0 || kexp_round_a !== 5'd1) begin errors++; $display("FAIL arst_pre: got busy=%b valid=%b round=%0d want 1/0/1", busy_a, rk_valid_a, kexp_round_a); end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy_a); end
    checks++; if (rk_valid_a !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", rk_valid_a); end
    checks++; if (kexp_round_a !== 5'd0) begin errors++; $display("FAIL arst_kexp_round: got %0d want 0", kexp_round_a); end
    checks++; if (kexp_key_a !== 128'h0) begin errors++; $display("FAIL arst_kexp_key: got %h want 0", kexp_key_a); end
    checks++; if (rk_data_a !== 128'h0) begin errors++; $display("FAIL arst_rk_data: got %h want 0", rk_data_a); end
    checks++; if (start_ready_a !== 1'b0) begin errors++; $display("FAIL arst_start_ready: got %b want 0", start_ready_a); end
    @(negedge clk);
    reset = 1'b0;
    start_a(K0);
    @(negedge clk);
    checks++; if (rk_valid_a !== 1'b1 || rk_round_a !== 5'd0) begin errors++; $display("FAIL arst_restart: got valid=%b round=%0d want 1/0", rk_valid_a, rk_round_a); end
    checks++; if (rk_data_a !== K0) begin errors++; $display("FAIL arst_restart_data: got %h want %h", rk_data_a, K0); end
    drain();
  endtask

  task automatic test_start_busy();
    rk_ready = 1'b1;
    @(negedge clk);
    start_valid_a = 1'b1;
    key_in = K0;
    @(negedge clk);
    key_in = K1;
    for (int t = 1; t <= 46; t++) begin
      @(negedge clk);
      if (t <= 21) begin
        checks++; if (kexp_key_a !== K0 || busy_a !== 1'b1) begin errors++; $display("FAIL sb_ignored t=%0d: got key=%h busy=%b want %h/1", t, kexp_key_a, busy_a, K0); end
      end
      if (t == 22) begin
        checks++; if (busy_a !== 1'b0 || start_ready_a !== 1'b1) begin errors++; $display("FAIL sb_idle: got busy=%b ready=%b want 0/1", busy_a, start_ready_a); end
      end
      if (t == 23) begin
        checks++; if (busy_a !== 1'b1 || kexp_key_a !== K1 || kexp_round_a !== 5'd0) begin errors++; $display("FAIL sb_accept: got busy=%b key=%h round=%0d want 1/%h/0", busy_a, kexp_key_a, kexp_round_a, K1); end
        start_valid_a = 1'b0;
      end
      if (t == 24) begin
        checks++; if (rk_valid_a !== 1'b1 || rk_data_a !== K1) begin errors++; $display("FAIL sb_round0: got valid=%b data=%h want 1/%h", rk_valid_a, rk_data_a, K1); end
      end
      if (t == 44) begin
        checks++; if (rk_round_a !== 5'd10 || rk_data_a !== exp_rk(K1, 10)) begin errors++; $display("FAIL sb_round10: got round=%0d data=%h want 10/%h", rk_round_a, rk_data_a, exp_rk(K1, 10)); end
      end
      if (t >= 45) begin
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL sb_once t=%0d: got busy=%b want 0", t, busy_a); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_latency();
    test_flush();
    test_async_reset();
    test_start_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
